// File: rtl/add_sum_accumulator.sv
// Batch accumulator behind the 4-bit adder: sums COUNT incoming beats, then
// holds the batch total and its overflow flag on a valid/ready output port.
module add_sum_accumulator #(
    parameter int SUM_W = 5,
    parameter int ACC_W = 12,
    parameter int COUNT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_ovf
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_acc;

    logic [ACC_W:0]   sum_ext;
    logic             accept;
    logic             last_beat;

    // Input is refused while a total waits, while clearing, and during reset.
    assign in_ready  = (state == ACCUM) & ~clear & ~rst;
    assign accept    = in_valid & in_ready;
    assign last_beat = (cnt == LAST_CNT);

    // One extra bit captures the carry out of the running total.
    assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - SUM_W){1'b0}}, in_sum};

    // NOTE: non-blocking assignments keep every register update based on
    // pre-edge values; reset is sampled synchronously, so rst is not in the list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            out_valid <= 1'b0;
            out_total <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (clear) begin
                        acc     <= '0;
                        cnt     <= '0;
                        ovf_acc <= 1'b0;
                    end else if (accept) begin
                        if (last_beat) begin
                            out_total <= sum_ext[ACC_W-1:0];
                            out_ovf   <= ovf_acc | sum_ext[ACC_W];
                            out_valid <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                            ovf_acc   <= 1'b0;
                            state     <= HOLD;
                        end else begin
                            acc     <= sum_ext[ACC_W-1:0];
                            ovf_acc <= ovf_acc | sum_ext[ACC_W];
                            cnt     <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // out_valid is always set in HOLD, so out_ready alone completes the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_add_sum_accumulator.sv
// Scoreboard bench: three accumulator instances (default, 8-bit x16, single-beat)
// driven with directed vectors; a negedge monitor checks every presented result.
module tb_add_sum_accumulator;

    typedef struct {
        logic [11:0] total;
        logic        ovf;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      clear;
    logic [2:0]      in_valid;
    logic [2:0]      out_ready;
    logic [2:0][4:0] in_sum;

    logic        rdy0, rdy1, rdy2;
    logic        vld0, vld1, vld2;
    logic        ovf0, ovf1, ovf2;
    logic [11:0] tot0, tot2;
    logic [7:0]  tot1;
    wire  [2:0]  rdy = {rdy2, rdy1, rdy0};

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add_sum_accumulator u_dflt (
        .clk(clk), .rst(rst), .clear(clear[0]), .in_valid(in_valid[0]), .in_ready(rdy0),
        .in_sum(in_sum[0]), .out_valid(vld0), .out_ready(out_ready[0]),
        .out_total(tot0), .out_ovf(ovf0)
    );

    add_sum_accumulator #(.ACC_W(8), .COUNT(16)) u_w8 (
        .clk(clk), .rst(rst), .clear(clear[1]), .in_valid(in_valid[1]), .in_ready(rdy1),
        .in_sum(in_sum[1]), .out_valid(vld1), .out_ready(out_ready[1]),
        .out_total(tot1), .out_ovf(ovf1)
    );

    add_sum_accumulator #(.COUNT(1)) u_c1 (
        .clk(clk), .rst(rst), .clear(clear[2]), .in_valid(in_valid[2]), .in_ready(rdy2),
        .in_sum(in_sum[2]), .out_valid(vld2), .out_ready(out_ready[2]),
        .out_total(tot2), .out_ovf(ovf2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [11:0] t, input logic o);
        exp_t e;
        e.total = t;
        e.ovf   = o;
        case (idx)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int idx);
        case (idx)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qfront(input int idx);
        case (idx)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpop(input int idx);
        case (idx)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic mon_one(input int idx, input logic v, input logic r,
                           input logic [11:0] t, input logic o);
        exp_t e;
        if (v !== 1'b1) return;
        if (qsize(idx) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result[%0d]: got total=%0d ovf=%0d expected none", idx, t, o);
        end else begin
            e = qfront(idx);
            check($sformatf("out_total[%0d]", idx), 32'(t), 32'(e.total));
            check($sformatf("out_ovf[%0d]", idx), 32'(o), 32'(e.ovf));
            if (r) qpop(idx);
        end
    endtask

    // Monitor: compares whatever is presented; pops only on a handshake.
    always @(negedge clk) begin
        mon_one(0, vld0, out_ready[0], tot0, ovf0);
        mon_one(1, vld1, out_ready[1], {4'b0, tot1}, ovf1);
        mon_one(2, vld2, out_ready[2], tot2, ovf2);
    end

    task automatic send(input int idx, input logic [4:0] v, output int acc_cyc);
        int budget;
        budget = 0;
        in_valid[idx] = 1'b1;
        in_sum[idx]   = v;
        forever begin
            @(negedge clk);
            if (rdy[idx]) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
            budget++;
            if (budget > 100) begin
                total++;
                bad++;
                $display("FAIL send_timeout[%0d]: got no in_ready expected in_ready=1", idx);
                acc_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic feed(input int idx, input logic [4:0] v, input int n,
                        input logic [11:0] et, input logic eo);
        int c;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) push_exp(idx, et, eo);
            send(idx, v, c);
        end
        in_valid[idx] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c1, c2, c3;
        rst       = 1'b1;
        clear     = '0;
        in_valid  = '0;
        out_ready = '0;
        in_sum    = '0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 32'(rdy), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", 32'({vld2, vld1, vld0}), 32'd0);
        check("rst_out_total", 32'(tot0), 32'd0);
        check("rst_out_ovf", 32'(ovf0), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: 8 x 3, result pulses for exactly one cycle
        out_ready = 3'b111;
        feed(0, 5'd3, 8, 12'd24, 1'b0);
        check("t1_valid_after_last", 32'(vld0), 32'd1);
        @(posedge clk);
        #1;
        check("t1_valid_one_cycle", 32'(vld0), 32'd0);

        // T2: 8 x 30 under back-pressure
        out_ready[0] = 1'b0;
        feed(0, 5'd30, 8, 12'd240, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_in_ready_hold", 32'(rdy0), 32'd0);
            check("t2_valid_hold", 32'(vld0), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("t2_in_ready_handshake", 32'(rdy0), 32'd0);
        @(posedge clk);
        #1;
        check("t2_in_ready_after", 32'(rdy0), 32'd1);
        check("t2_valid_after", 32'(vld0), 32'd0);

        // T3: ACC_W=8, COUNT=16 overflow and recovery
        feed(1, 5'd31, 16, 12'd240, 1'b1);
        feed(1, 5'd1, 16, 12'd16, 1'b0);

        // T4: clear discards a partial batch and blocks the concurrent beat
        feed(0, 5'd7, 5, 12'd0, 1'b0);
        void'(q0.pop_back());
        clear[0]    = 1'b1;
        in_valid[0] = 1'b1;
        in_sum[0]   = 5'd9;
        @(negedge clk);
        check("t4_in_ready_clear", 32'(rdy0), 32'd0);
        @(posedge clk);
        #1;
        clear[0]    = 1'b0;
        in_valid[0] = 1'b0;
        feed(0, 5'd2, 8, 12'd16, 1'b0);

        // T5: reset while holding a result
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        feed(0, 5'd4, 8, 12'd32, 1'b0);
        @(negedge clk);
        check("t5_valid_before_rst", 32'(vld0), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("t5_in_ready_rst", 32'(rdy0), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_valid_after_rst", 32'(vld0), 32'd0);
        check("t5_total_after_rst", 32'(tot0), 32'd0);
        check("t5_ovf_after_rst", 32'(ovf0), 32'd0);
        check("t5_pending_count", 32'(q0.size()), 32'd1);
        q0.delete();
        out_ready[0] = 1'b1;
        feed(0, 5'd1, 8, 12'd8, 1'b0);

        // T6: COUNT=1, back-to-back offers accepted every second cycle
        push_exp(2, 12'd5, 1'b0);
        send(2, 5'd5, c1);
        push_exp(2, 12'd17, 1'b0);
        send(2, 5'd17, c2);
        push_exp(2, 12'd31, 1'b0);
        send(2, 5'd31, c3);
        in_valid[2] = 1'b0;
        check("t6_gap_1", 32'(c2 - c1), 32'd2);
        check("t6_gap_2", 32'(c3 - c2), 32'd2);

        repeat (4) @(posedge clk);
        #1;
        check("drain_q0", 32'(q0.size()), 32'd0);
        check("drain_q1", 32'(q1.size()), 32'd0);
        check("drain_q2", 32'(q2.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
